// File: rtl/uart_tx_poll_pkg.sv
// uart_tx_pkg: shared states, frame constants and register offsets for uart_tx_poll.
// FRAME_BITS follows the UART_TX_PARITY_EN build macro.
package uart_tx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
    localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;
endpackage

// File: rtl/uart_tx_poll_if.sv
// uart_tx_poll_if: CPU-side register bus plus serial line of the polled transmitter.
interface uart_tx_poll_if;
    logic        a0;
    logic        wt;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        txd;
    modport master (output a0, wt, data_in, input data_out, txd);
    modport slave  (input a0, wt, data_in, output data_out, txd);
endinterface

// File: rtl/uart_tx_poll_baud_gen.sv
// baud_gen: free-running 0..CLKS_PER_BIT-1 counter with a one-cycle tick at terminal count.
// restart zeroes the count so the following bit period is full length.
module baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    logic [W-1:0] r_cnt;
    assign tick = !restart && r_cnt == W'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk) begin
        if (reset || restart) r_cnt <= '0;
        else                  r_cnt <= tick ? '0 : r_cnt + W'(1);
    end
endmodule

// File: rtl/uart_tx_poll.sv
// uart_tx_poll: polled memory-mapped 8N1 transmitter (8E1 when UART_TX_PARITY_EN is defined).
// DATA write starts a frame when ready; STATUS reads back the ready flag.
module uart_tx_poll
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_poll_if.slave  bus
);
    tx_state_t  r_state, w_state_n;
    logic [2:0] r_bit, w_bit_n, w_next_bit;
    logic [7:0] r_byte, w_byte_n;
    logic       r_txd, w_txd_n, r_ready, w_ready_n;
    logic       w_accept, w_tick;

    assign w_accept     = bus.wt && bus.a0 == REG_DATA && r_ready;
    assign w_next_bit   = r_bit + 3'd1;
    assign bus.txd      = r_txd;
    assign bus.data_out = bus.a0 == REG_STATUS ? {15'h0000, r_ready} : {8'h00, r_byte};

    baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk     (clk),
        .reset   (reset),
        .restart (w_accept),
        .tick    (w_tick)
    );

    always_comb begin
        w_state_n = r_state;
        w_bit_n   = r_bit;
        w_byte_n  = r_byte;
        w_txd_n   = r_txd;
        w_ready_n = r_ready;
        case (r_state)
            IDLE: if (w_accept) begin
                w_state_n = START;
                w_byte_n  = bus.data_in[7:0];
                w_ready_n = 1'b0;
                w_txd_n   = 1'b0;
                w_bit_n   = '0;
            end
            START: if (w_tick) begin
                w_state_n = DATA;
                w_txd_n   = r_byte[0];
            end
            DATA: if (w_tick) begin
                if (r_bit == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_n = PARITY;
                    w_txd_n   = ^r_byte;
`else
                    w_state_n = STOP;
                    w_txd_n   = 1'b1;
`endif
                end else begin
                    w_bit_n = w_next_bit;
                    w_txd_n = r_byte[w_next_bit];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (w_tick) begin
                w_state_n = STOP;
                w_txd_n   = 1'b1;
            end
`endif
            STOP: if (w_tick) begin
                w_state_n = IDLE;
                w_ready_n = 1'b1;
            end
            default: begin
                w_state_n = IDLE;
                w_txd_n   = 1'b1;
                w_ready_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_bit   <= '0;
            r_byte  <= 8'h00;
            r_txd   <= 1'b1;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_bit   <= w_bit_n;
            r_byte  <= w_byte_n;
            r_txd   <= w_txd_n;
            r_ready <= w_ready_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_poll.sv
// tb_uart_tx_poll: directed plus random frames checked against a bit-list frame model.
module tb_uart_tx_poll;
    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    uart_tx_poll_if bus();
    uart_tx_poll #(.CLKS_PER_BIT(C)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Line level k cycles after the accepting edge: frame is start, 8 data LSB-first, [parity], stop.
    function automatic logic exp_txd(input logic [7:0] b, input int k);
        int slot = k / C;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (F == 11 && slot == 9) return ^b;
        return 1'b1;
    endfunction

    // Entered at a negedge with ready=1; leaves at the negedge of the first ready cycle after the frame.
    task automatic frame(input logic [15:0] w, input bit busy_writes, input int rst_at);
        bus.a0 = 1'b0; bus.wt = 1'b1; bus.data_in = w;
        @(posedge clk);
        for (int k = 0; k < F * C; k++) begin
            @(negedge clk);
            bus.wt = 1'b0; bus.a0 = 1'b1;
            if (k == rst_at) begin
                reset = 1'b1; bus.wt = 1'b1; bus.a0 = 1'b0; bus.data_in = 16'h00C3;
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0; bus.wt = 1'b0;
                #1 check("rst_data", bus.data_out, 16'h0000);
                bus.a0 = 1'b1;
                #1 check("rst_ready", bus.data_out, 16'h0001);
                check("rst_txd", {15'h0, bus.txd}, 16'h0001);
                return;
            end
            if (busy_writes && k == 10) begin
                bus.a0 = 1'b0; bus.wt = 1'b1; bus.data_in = 16'h00F0;
            end
            if (busy_writes && k == 11) begin
                bus.wt = 1'b1; bus.data_in = 16'h0033;
            end
            #1 check($sformatf("txd[%0d]", k), {15'h0, bus.txd}, {15'h0, exp_txd(w[7:0], k)});
            check($sformatf("rd[%0d]", k), bus.data_out, bus.a0 ? 16'h0000 : {8'h00, w[7:0]});
        end
        @(negedge clk);
        bus.wt = 1'b0; bus.a0 = 1'b1;
        #1 check("ready_back", bus.data_out, 16'h0001);
        check("txd_idle", {15'h0, bus.txd}, 16'h0001);
    endtask

    initial begin
        logic [15:0] w;
        reset = 1'b1; bus.wt = 1'b0; bus.a0 = 1'b1; bus.data_in = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("reset_status", bus.data_out, 16'h0001);
            check("reset_txd", {15'h0, bus.txd}, 16'h0001);
        end
        bus.a0 = 1'b0;
        #1 check("reset_data", bus.data_out, 16'h0000);
        frame(16'hAB55, 1'b0, -1);
        bus.a0 = 1'b0;
        #1 check("data_55", bus.data_out, 16'h0055);
        frame(16'h0055, 1'b1, -1);
        bus.a0 = 1'b0;
        #1 check("data_after_busy", bus.data_out, 16'h0055);
        frame(16'h0012, 1'b0, -1);
        frame(16'h0034, 1'b0, 17);
        frame(16'h0001, 1'b0, -1);
        frame(16'h0007, 1'b0, -1);
        frame(16'h0003, 1'b0, -1);
        for (int i = 0; i < 8; i++) begin
            w = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            frame(w, 1'b0, -1);
            bus.a0 = 1'b0;
            #1 check("data_rand", bus.data_out, {8'h00, w[7:0]});
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
